// File: rtl/wb_tag_timeout_slice.sv
// Registered tagged Wishbone bridge for the interconnect passthrough port. Every access is
// cut by flops on both sides and bounded by a timeout that aborts downstream and errs upstream.
module wb_tag_timeout_slice #(
  parameter int ADR_WIDTH = 32,
  parameter int DAT_WIDTH = 32,
  parameter int TGA_WIDTH = 4,
  parameter int TGD_WIDTH = 4,
  parameter int TGC_WIDTH = 4,
  parameter int TIMEOUT   = 256
) (
  input  logic                   clock,
  input  logic                   reset,
  // upstream (target side, driven by the interconnect)
  input  logic [ADR_WIDTH-1:0]   t_adr,
  input  logic [DAT_WIDTH-1:0]   t_dat_w,
  input  logic [DAT_WIDTH/8-1:0] t_sel,
  input  logic                   t_we,
  input  logic                   t_cyc,
  input  logic                   t_stb,
  input  logic [TGA_WIDTH-1:0]   t_tga,
  input  logic [TGC_WIDTH-1:0]   t_tgc,
  input  logic [TGD_WIDTH-1:0]   t_tgd_w,
  output logic [DAT_WIDTH-1:0]   t_dat_r,
  output logic [TGD_WIDTH-1:0]   t_tgd_r,
  output logic                   t_ack,
  output logic                   t_err,
  // downstream (initiator side, toward the external fabric)
  output logic [ADR_WIDTH-1:0]   i_adr,
  output logic [DAT_WIDTH-1:0]   i_dat_w,
  output logic [DAT_WIDTH/8-1:0] i_sel,
  output logic                   i_we,
  output logic                   i_cyc,
  output logic                   i_stb,
  output logic [TGA_WIDTH-1:0]   i_tga,
  output logic [TGC_WIDTH-1:0]   i_tgc,
  output logic [TGD_WIDTH-1:0]   i_tgd_w,
  input  logic [DAT_WIDTH-1:0]   i_dat_r,
  input  logic [TGD_WIDTH-1:0]   i_tgd_r,
  input  logic                   i_ack,
  input  logic                   i_err,
  // timeout reporting
  output logic                   to_event,
  output logic [ADR_WIDTH-1:0]   to_adr
);

  localparam int SEL_WIDTH = DAT_WIDTH / 8;
  localparam int CNT_WIDTH = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit TO_EN     = (TIMEOUT != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = TO_EN ? CNT_WIDTH'(TIMEOUT - 1) : CNT_ZERO;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ADR_WIDTH-1:0]   i_adr_q, i_adr_d;
  logic [DAT_WIDTH-1:0]   i_dat_w_q, i_dat_w_d;
  logic [SEL_WIDTH-1:0]   i_sel_q, i_sel_d;
  logic                   i_we_q, i_we_d;
  logic [TGA_WIDTH-1:0]   i_tga_q, i_tga_d;
  logic [TGC_WIDTH-1:0]   i_tgc_q, i_tgc_d;
  logic [TGD_WIDTH-1:0]   i_tgd_w_q, i_tgd_w_d;
  logic                   i_vld_q, i_vld_d;
  logic [DAT_WIDTH-1:0]   t_dat_r_q, t_dat_r_d;
  logic [TGD_WIDTH-1:0]   t_tgd_r_q, t_tgd_r_d;
  logic                   t_ack_q, t_ack_d;
  logic                   t_err_q, t_err_d;
  logic                   to_event_q, to_event_d;
  logic [ADR_WIDTH-1:0]   to_adr_q, to_adr_d;

  logic req_start_s;
  logic rsp_in_s;
  logic timeout_s;

  assign req_start_s = t_cyc & t_stb;
  assign rsp_in_s    = i_ack | i_err;
  assign timeout_s   = TO_EN && (cnt_q == CNT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Response and timeout outrank an upstream abort seen in the same REQ cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_start_s) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (rsp_in_s || timeout_s) begin
          state_d = ST_RSP;
        end else if (!t_cyc) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_RSP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    i_adr_d    = i_adr_q;
    i_dat_w_d  = i_dat_w_q;
    i_sel_d    = i_sel_q;
    i_we_d     = i_we_q;
    i_tga_d    = i_tga_q;
    i_tgc_d    = i_tgc_q;
    i_tgd_w_d  = i_tgd_w_q;
    i_vld_d    = 1'b0;
    t_dat_r_d  = t_dat_r_q;
    t_tgd_r_d  = t_tgd_r_q;
    t_ack_d    = 1'b0;
    t_err_d    = 1'b0;
    to_event_d = 1'b0;
    to_adr_d   = to_adr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_start_s) begin
          i_adr_d   = t_adr;
          i_dat_w_d = t_dat_w;
          i_sel_d   = t_sel;
          i_we_d    = t_we;
          i_tga_d   = t_tga;
          i_tgc_d   = t_tgc;
          i_tgd_w_d = t_tgd_w;
          i_vld_d   = 1'b1;
          cnt_d     = CNT_ZERO;
        end else begin
          i_vld_d   = 1'b0;
        end
      end
      ST_REQ: begin
        if (rsp_in_s) begin
          t_dat_r_d = i_dat_r;
          t_tgd_r_d = i_tgd_r;
          t_ack_d   = i_ack;
          t_err_d   = i_err & ~i_ack;
        end else if (timeout_s) begin
          t_err_d    = 1'b1;
          to_event_d = 1'b1;
          to_adr_d   = i_adr_q;
        end else if (t_cyc) begin
          i_vld_d = 1'b1;
          cnt_d   = cnt_q + CNT_ONE;
        end else begin
          i_vld_d = 1'b0;
        end
      end
      ST_RSP: begin
        i_vld_d = 1'b0;
      end
      default: begin
        i_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q      <= CNT_ZERO;
      i_adr_q    <= {ADR_WIDTH{1'b0}};
      i_dat_w_q  <= {DAT_WIDTH{1'b0}};
      i_sel_q    <= {SEL_WIDTH{1'b0}};
      i_we_q     <= 1'b0;
      i_tga_q    <= {TGA_WIDTH{1'b0}};
      i_tgc_q    <= {TGC_WIDTH{1'b0}};
      i_tgd_w_q  <= {TGD_WIDTH{1'b0}};
      i_vld_q    <= 1'b0;
      t_dat_r_q  <= {DAT_WIDTH{1'b0}};
      t_tgd_r_q  <= {TGD_WIDTH{1'b0}};
      t_ack_q    <= 1'b0;
      t_err_q    <= 1'b0;
      to_event_q <= 1'b0;
      to_adr_q   <= {ADR_WIDTH{1'b0}};
    end else begin
      cnt_q      <= cnt_d;
      i_adr_q    <= i_adr_d;
      i_dat_w_q  <= i_dat_w_d;
      i_sel_q    <= i_sel_d;
      i_we_q     <= i_we_d;
      i_tga_q    <= i_tga_d;
      i_tgc_q    <= i_tgc_d;
      i_tgd_w_q  <= i_tgd_w_d;
      i_vld_q    <= i_vld_d;
      t_dat_r_q  <= t_dat_r_d;
      t_tgd_r_q  <= t_tgd_r_d;
      t_ack_q    <= t_ack_d;
      t_err_q    <= t_err_d;
      to_event_q <= to_event_d;
      to_adr_q   <= to_adr_d;
    end
  end

  assign i_adr    = i_adr_q;
  assign i_dat_w  = i_dat_w_q;
  assign i_sel    = i_sel_q;
  assign i_we     = i_we_q;
  assign i_cyc    = i_vld_q;
  assign i_stb    = i_vld_q;
  assign i_tga    = i_tga_q;
  assign i_tgc    = i_tgc_q;
  assign i_tgd_w  = i_tgd_w_q;
  assign t_dat_r  = t_dat_r_q;
  assign t_tgd_r  = t_tgd_r_q;
  assign t_ack    = t_ack_q;
  assign t_err    = t_err_q;
  assign to_event = to_event_q;
  assign to_adr   = to_adr_q;

endmodule
